// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles both requester channels and the RAM port of the
// two-requester RAM arbiter.
//   a_* / b_*   : requester channels (req, write, addr, wdata in;
//                 gnt, rvalid, err out)
//   rdata       : shared read-data return
//   ram_*       : RAM strobes, address, write data and registered read data
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the RAM model
interface ram_arbiter_if;
    logic        a_req;
    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_gnt;
    logic        a_rvalid;
    logic        a_err;

    logic        b_req;
    logic        b_write;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_gnt;
    logic        b_rvalid;
    logic        b_err;

    logic [31:0] rdata;

    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_address;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_rdata;

    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        input  b_req, b_write, b_addr, b_wdata,
        input  ram_rdata,
        output a_gnt, a_rvalid, a_err,
        output b_gnt, b_rvalid, b_err,
        output rdata,
        output ram_read, ram_write, ram_address, ram_dataIn
    );

    modport master (
        output a_req, a_write, a_addr, a_wdata,
        output b_req, b_write, b_addr, b_wdata,
        output ram_rdata,
        input  a_gnt, a_rvalid, a_err,
        input  b_gnt, b_rvalid, b_err,
        input  rdata,
        input  ram_read, ram_write, ram_address, ram_dataIn
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates two requesters (A, B) onto a single-port RAM with
// a registered read output. One access is accepted per cycle; a requester
// keeps ownership for up to MAX_BURST consecutive grants while the other
// waits. Accesses at or above ADDR_LIMIT are accepted but never reach the
// RAM; they return rvalid with err one cycle later.
// Ports:
//   clk     - clock, all state on posedge
//   reset_n - asynchronous active-low reset
//   bus     - ram_arbiter_if.slave: requester channels and RAM port
module ram_arbiter #(
    parameter int MAX_BURST  = 4,
    parameter int ADDR_LIMIT = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    ram_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    typedef enum logic {OWNER_A, OWNER_B} owner_t;

    state_t           state;
    owner_t           last_owner;
    logic [CNT_W-1:0] burst_cnt;

    logic gnt_a, gnt_b;
    logic a_oor, b_oor;
    logic burst_open;
    logic a_rvalid_q, a_err_q, b_rvalid_q, b_err_q;

    assign a_oor      = bus.a_addr >= 32'(ADDR_LIMIT);
    assign b_oor      = bus.b_addr >= 32'(ADDR_LIMIT);
    assign burst_open = burst_cnt < MAX_CNT;

    // Grant decision; gated by reset_n so nothing is granted while the
    // asynchronous reset is held even though requests may be present.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        case (state)
            IDLE: begin
                if (bus.a_req && bus.b_req) begin
                    gnt_a = (last_owner == OWNER_B);
                    gnt_b = (last_owner == OWNER_A);
                end else begin
                    gnt_a = bus.a_req;
                    gnt_b = bus.b_req;
                end
            end
            OWN_A: begin
                gnt_a = bus.a_req && (!bus.b_req || burst_open);
                gnt_b = bus.b_req && !gnt_a;
            end
            OWN_B: begin
                gnt_b = bus.b_req && (!bus.a_req || burst_open);
                gnt_a = bus.a_req && !gnt_b;
            end
            default: begin
                gnt_a = 1'b0;
                gnt_b = 1'b0;
            end
        endcase
        gnt_a = gnt_a && reset_n;
        gnt_b = gnt_b && reset_n;
    end

    // RAM port: only a granted in-range access strobes the RAM.
    always_comb begin
        bus.ram_read    = 1'b0;
        bus.ram_write   = 1'b0;
        bus.ram_address = '0;
        bus.ram_dataIn  = '0;
        if (gnt_a) begin
            bus.ram_read    = !bus.a_write && !a_oor;
            bus.ram_write   =  bus.a_write && !a_oor;
            bus.ram_address = bus.a_addr;
            bus.ram_dataIn  = bus.a_wdata;
        end else if (gnt_b) begin
            bus.ram_read    = !bus.b_write && !b_oor;
            bus.ram_write   =  bus.b_write && !b_oor;
            bus.ram_address = bus.b_addr;
            bus.ram_dataIn  = bus.b_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= OWNER_B;
            burst_cnt  <= '0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
        end else begin
            // Reads and any out-of-range access return a response next cycle.
            a_rvalid_q <= gnt_a && (!bus.a_write || a_oor);
            a_err_q    <= gnt_a && a_oor;
            b_rvalid_q <= gnt_b && (!bus.b_write || b_oor);
            b_err_q    <= gnt_b && b_oor;

            if (gnt_a) begin
                state      <= OWN_A;
                last_owner <= OWNER_A;
                if (state == OWN_A)
                    burst_cnt <= burst_open ? burst_cnt + 1'b1 : burst_cnt;
                else
                    burst_cnt <= CNT_W'(1);
            end else if (gnt_b) begin
                state      <= OWN_B;
                last_owner <= OWNER_B;
                if (state == OWN_B)
                    burst_cnt <= burst_open ? burst_cnt + 1'b1 : burst_cnt;
                else
                    burst_cnt <= CNT_W'(1);
            end else if (state != IDLE) begin
                // last_owner already holds the owner that just went quiet.
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.a_err    = a_err_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_err    = b_err_q;
    assign bus.rdata    = bus.ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// 32-word registered-read RAM model attached to the RAM port.
module tb_ram_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   fails;

    logic [31:0] mem [0:31];

    ram_arbiter_if bus ();

    ram_arbiter #(
        .MAX_BURST  (4),
        .ADDR_LIMIT (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write on the strobe edge, read data registered one cycle.
    always @(posedge clk) begin
        if (bus.ram_write)
            mem[bus.ram_address[4:0]] <= bus.ram_dataIn;
        if (bus.ram_read)
            bus.ram_rdata <= mem[bus.ram_address[4:0]];
    end

    task automatic idle_inputs();
        bus.a_req   = 1'b0;
        bus.a_write = 1'b0;
        bus.a_addr  = '0;
        bus.a_wdata = '0;
        bus.b_req   = 1'b0;
        bus.b_write = 1'b0;
        bus.b_addr  = '0;
        bus.b_wdata = '0;
    endtask

    // Move to just after the next active edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        bus.a_req   = 1'b1;
        bus.b_req   = 1'b1;
        bus.a_addr  = 32'd5;
        bus.b_addr  = 32'd6;
        #1;
        checks++; if (bus.a_gnt !== 1'b0) begin fails++; $display("FAIL reset_a_gnt: got %b want 0", bus.a_gnt); end
        checks++; if (bus.b_gnt !== 1'b0) begin fails++; $display("FAIL reset_b_gnt: got %b want 0", bus.b_gnt); end
        checks++; if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0) begin fails++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", bus.ram_read, bus.ram_write); end
        checks++; if ({bus.a_rvalid, bus.a_err, bus.b_rvalid, bus.b_err} !== 4'b0000) begin fails++; $display("FAIL reset_resp: got %b want 0000", {bus.a_rvalid, bus.a_err, bus.b_rvalid, bus.b_err}); end
        checks++; if (dut.burst_cnt !== 3'd0) begin fails++; $display("FAIL reset_burst_cnt: got %0d want 0", dut.burst_cnt); end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        next_cycle();
        bus.a_req = 1'b1; bus.a_write = 1'b1; bus.a_addr = 32'd3; bus.a_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin fails++; $display("FAIL wr_gnt: got a=%b b=%b want 1/0", bus.a_gnt, bus.b_gnt); end
        checks++; if (bus.ram_write !== 1'b1 || bus.ram_read !== 1'b0) begin fails++; $display("FAIL wr_strobe: got wr=%b rd=%b want 1/0", bus.ram_write, bus.ram_read); end
        checks++; if (bus.ram_address !== 32'd3 || bus.ram_dataIn !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bus: got addr=%h data=%h want 3/deadbeef", bus.ram_address, bus.ram_dataIn); end
        next_cycle();
        bus.a_write = 1'b0;
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1 || bus.ram_read !== 1'b1) begin fails++; $display("FAIL rd_gnt: got gnt=%b rd=%b want 1/1", bus.a_gnt, bus.ram_read); end
        checks++; if (bus.a_rvalid !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid: got %b want 0", bus.a_rvalid); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.a_rvalid !== 1'b1 || bus.a_err !== 1'b0) begin fails++; $display("FAIL rd_resp: got rvalid=%b err=%b want 1/0", bus.a_rvalid, bus.a_err); end
        checks++; if (bus.rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h want deadbeef", bus.rdata); end
        checks++; if (bus.b_rvalid !== 1'b0) begin fails++; $display("FAIL rd_b_quiet: got %b want 0", bus.b_rvalid); end
        checks++; if (bus.ram_address !== 32'd0 || bus.ram_dataIn !== 32'd0 || bus.ram_read !== 1'b0) begin fails++; $display("FAIL idle_bus: got addr=%h data=%h rd=%b want 0", bus.ram_address, bus.ram_dataIn, bus.ram_read); end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        do_reset();
        next_cycle();
        bus.a_req = 1'b1; bus.a_addr = 32'd1;
        bus.b_req = 1'b1; bus.b_addr = 32'd2;
        for (int i = 0; i < 12; i++) begin
            exp_a = ((i / 4) % 2) == 0;
            @(negedge clk);
            checks++; if (bus.a_gnt !== exp_a || bus.b_gnt !== !exp_a) begin fails++; $display("FAIL rr_cycle%0d: got a=%b b=%b want a=%b b=%b", i, bus.a_gnt, bus.b_gnt, exp_a, !exp_a); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        next_cycle();
        bus.b_req = 1'b1; bus.b_write = 1'b0; bus.b_addr = 32'd40;
        @(negedge clk);
        checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin fails++; $display("FAIL oor_gnt: got a=%b b=%b want 0/1", bus.a_gnt, bus.b_gnt); end
        checks++; if (bus.ram_read !== 1'b0 || bus.ram_write !== 1'b0) begin fails++; $display("FAIL oor_rd_strobe: got rd=%b wr=%b want 0/0", bus.ram_read, bus.ram_write); end
        next_cycle();
        bus.b_write = 1'b1; bus.b_addr = 32'd32; bus.b_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_err !== 1'b1) begin fails++; $display("FAIL oor_rd_resp: got rvalid=%b err=%b want 1/1", bus.b_rvalid, bus.b_err); end
        checks++; if (bus.b_gnt !== 1'b1 || bus.ram_write !== 1'b0) begin fails++; $display("FAIL oor_wr_strobe: got gnt=%b wr=%b want 1/0", bus.b_gnt, bus.ram_write); end
        next_cycle();
        bus.b_addr = 32'd31; bus.b_wdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (bus.b_rvalid !== 1'b1 || bus.b_err !== 1'b1) begin fails++; $display("FAIL oor_wr_resp: got rvalid=%b err=%b want 1/1", bus.b_rvalid, bus.b_err); end
        checks++; if (bus.ram_write !== 1'b1 || bus.ram_address !== 32'd31) begin fails++; $display("FAIL top_addr_wr: got wr=%b addr=%h want 1/1f", bus.ram_write, bus.ram_address); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.b_rvalid !== 1'b0 || bus.b_err !== 1'b0) begin fails++; $display("FAIL inrange_wr_no_resp: got rvalid=%b err=%b want 0/0", bus.b_rvalid, bus.b_err); end
    endtask

    task automatic test_burst_switch();
        next_cycle();
        bus.a_req = 1'b1; bus.a_addr = 32'd4;
        bus.b_req = 1'b1; bus.b_addr = 32'd5;
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin fails++; $display("FAIL burst_g1: got a=%b b=%b want 1/0", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin fails++; $display("FAIL burst_g2: got a=%b b=%b want 1/0", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        bus.a_req = 1'b0;
        @(negedge clk);
        checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin fails++; $display("FAIL burst_switch: got a=%b b=%b want 0/1", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        bus.a_req = 1'b1;
        @(negedge clk);
        checks++; if (dut.burst_cnt !== 3'd1) begin fails++; $display("FAIL burst_restart: got %0d want 1", dut.burst_cnt); end
        checks++; if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin fails++; $display("FAIL burst_b_keeps: got a=%b b=%b want 0/1", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_idle_tie();
        next_cycle();
        bus.a_req = 1'b1; bus.a_addr = 32'd7;
        bus.b_req = 1'b1; bus.b_addr = 32'd8;
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin fails++; $display("FAIL idle_tie: got a=%b b=%b want 1/0", bus.a_gnt, bus.b_gnt); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_inflight();
        next_cycle();
        bus.a_req = 1'b1; bus.a_write = 1'b0; bus.a_addr = 32'd3;
        @(negedge clk);
        checks++; if (bus.a_gnt !== 1'b1) begin fails++; $display("FAIL inflight_gnt: got %b want 1", bus.a_gnt); end
        next_cycle();
        reset_n = 1'b0;
        #1;
        checks++; if (bus.a_rvalid !== 1'b0 || bus.a_err !== 1'b0) begin fails++; $display("FAIL inflight_dropped: got rvalid=%b err=%b want 0/0", bus.a_rvalid, bus.a_err); end
        checks++; if (bus.a_gnt !== 1'b0 || bus.ram_read !== 1'b0) begin fails++; $display("FAIL inflight_outputs: got gnt=%b rd=%b want 0/0", bus.a_gnt, bus.ram_read); end
        @(negedge clk);
        checks++; if (bus.a_rvalid !== 1'b0) begin fails++; $display("FAIL inflight_hold: got %b want 0", bus.a_rvalid); end
        idle_inputs();
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_burst_switch();
        test_idle_tie();
        test_reset_inflight();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the max consecutive grants to one requester while the other is waiting.
REQ-002 Parameter ADDR_LIMIT, default 32, SHALL set the number of addressable RAM words; valid addresses are 0..ADDR_LIMIT-1.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on posedge clk.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 a_req / b_req  in  1  SHALL mean the requester has an access pending; it stays asserted with stable fields until its gnt.
REQ-006 a_write / b_write  in  1  SHALL select write (1) or read (0).
REQ-007 a_addr / b_addr  in  32  SHALL carry the word address.
REQ-008 a_wdata / b_wdata  in  32  SHALL carry the write data.
REQ-009 a_gnt / b_gnt  out  1  SHALL mean the access is accepted this cycle (combinational).
REQ-010 a_rvalid / b_rvalid  out  1  SHALL mean the read response or error is valid this cycle.
REQ-011 a_err / b_err  out  1  SHALL flag an out-of-range access and is qualified by rvalid.
REQ-012 rdata  out  32  SHALL be the shared read-data return, equal to ram_rdata.
REQ-013 ram_read / ram_write  out  1  SHALL be the RAM strobes.
REQ-014 ram_address / ram_dataIn  out  32  SHALL be the RAM address and write data.
REQ-015 ram_rdata  in  32  SHALL be the RAM registered read output, valid one cycle after ram_read.

Function
REQ-016 FSM states SHALL be IDLE, OWN_A and OWN_B, plus a burst_cnt register and a last_owner register.
REQ-017 In IDLE with one req, that requester SHALL be granted; with both, the one that is not last_owner SHALL be granted.
REQ-018 On any grant from IDLE or on an ownership switch, the state SHALL become OWN_winner and burst_cnt SHALL become 1.
REQ-019 In OWN_X, X SHALL be granted again (burst_cnt+1, saturating at MAX_BURST) if X req && (!other req || burst_cnt < MAX_BURST).
REQ-020 In OWN_X, the other requester SHALL be granted and ownership SHALL switch if it has req and X is not re-granted.
REQ-021 In OWN_X with no req from either requester, the next state SHALL be IDLE with last_owner = X.
REQ-022 At most one gnt SHALL be asserted per cycle; throughput SHALL be one access per cycle with back-to-back grants allowed.
REQ-023 For a granted in-range access, ram_read = ~write, ram_write = write, and ram_address/ram_dataIn SHALL come from the winner in the same cycle.
REQ-024 For a granted out-of-range access (addr >= ADDR_LIMIT), both RAM strobes SHALL stay 0; the access still consumes a grant slot.
REQ-025 Without a grant, ram_read = ram_write = 0 and ram_address = ram_dataIn = 0.
REQ-026 A granted in-range read SHALL give winner rvalid=1, err=0 exactly one cycle later, with rdata = the RAM word.
REQ-027 A granted out-of-range read or write SHALL give winner rvalid=1, err=1 one cycle later.
REQ-028 An in-range write SHALL produce no rvalid.
REQ-029 A read to the address written in the previous cycle SHALL return the new data; the arbiter adds no forwarding.

Reset
REQ-030 While reset_n=0, the state SHALL be IDLE, last_owner = B (so A wins the first tie), and burst_cnt = 0.
REQ-031 While reset_n=0, all gnt, rvalid, err, ram_read and ram_write SHALL be 0.
REQ-032 An asserted reset SHALL drop any in-flight response.

Verification
REQ-033 Scenario: A writes 0xDEADBEEF to addr 3, then reads addr 3 -> a_gnt both cycles; a_rvalid one cycle after the read gnt with rdata 0xDEADBEEF and a_err 0.
REQ-034 Scenario: from reset, both req continuously (reads) -> grants A,A,A,A,B,B,B,B,A... with exactly one gnt per cycle.
REQ-035 Scenario: B only, read at addr 40 -> b_gnt, no RAM strobe; next cycle b_rvalid=1 and b_err=1.
REQ-036 Scenario: A ends its burst after 2 grants while B waits -> B granted in the next cycle and burst_cnt restarts at 1.
REQ-037 Scenario: reset_n asserted in the cycle after a read gnt -> no rvalid; all outputs 0 immediately (asynchronously).
REQ-038 Scenario: both idle after B's access, then both req simultaneously -> A granted first.
